// File: rtl/display_scan_sequencer_pkg.sv
// rtl/display_scan_sequencer_pkg.sv - shared types, constants and digit search for the scan sequencer
package display_scan_sequencer_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    // Nearest set bit of mask strictly after cur, wrapping 7->0; cur=7 yields the lowest set bit.
    function automatic logic [IDX_W-1:0] next_enabled_idx(
        input logic [IDX_W-1:0]      cur,
        input logic [NUM_DIGITS-1:0] mask
    );
        logic [IDX_W-1:0]        sh;
        logic [2*NUM_DIGITS-1:0] dbl;
        logic [NUM_DIGITS-1:0]   rot;
        logic [IDX_W-1:0]        res;
        logic                    found;
        sh    = cur + IDX_W'(1);
        dbl   = {mask, mask} >> sh;
        rot   = dbl[NUM_DIGITS-1:0];
        res   = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (!found && rot[j]) begin
                res   = sh + IDX_W'(j);
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/display_scan_sequencer_decoder3to8.sv
// rtl/display_scan_sequencer_decoder3to8.sv - 3-bit index to 8-bit one-hot decoder
module decoder3to8 (
    input  logic [2:0] idx_i,
    output logic [7:0] onehot_o
);

    assign onehot_o = 8'b0000_0001 << idx_i;

endmodule

// File: rtl/display_scan_sequencer.sv
// rtl/display_scan_sequencer.sv - time-multiplexed 8-digit scan with dwell, blanking and pattern store
module display_scan_sequencer
    import display_scan_sequencer_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] mask_i,
    input  logic       wr_en_i,
    input  logic [2:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    output logic [2:0] sel_idx_o,
    output logic       sel_valid_o,
    output logic [7:0] digit_sel_o,
    output logic [7:0] seg_o,
    output logic       frame_done_o
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    scan_state_e           state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  frame_done_q;
    logic [7:0]            pat_q [NUM_DIGITS];

    logic [IDX_W-1:0]      adv_idx;
    logic                  adv_wrap;
    logic                  advance;
    logic                  sel_valid;
    logic [NUM_DIGITS-1:0] dec_onehot;

    assign adv_idx  = next_enabled_idx(idx_q, mask_i);
    assign adv_wrap = (adv_idx <= idx_q);

    // With no blanking the last dwell cycle hands straight over to the next digit.
    assign advance = ((state_q == ST_DRIVE) && (cnt_q == DWELL_LAST) && (BLANK_CYCLES == 0))
                  || ((state_q == ST_BLANK) && (cnt_q == BLANK_LAST));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!en_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else if (advance) begin
                cnt_q <= '0;
                if (mask_i == '0) begin
                    state_q <= ST_IDLE;
                end else begin
                    state_q      <= ST_DRIVE;
                    idx_q        <= adv_idx;
                    frame_done_q <= adv_wrap;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (mask_i != '0) begin
                            state_q <= ST_DRIVE;
                            idx_q   <= next_enabled_idx(IDX_W'(NUM_DIGITS - 1), mask_i);
                            cnt_q   <= '0;
                        end
                    end
                    ST_DRIVE: begin
                        if (cnt_q == DWELL_LAST) begin
                            state_q <= ST_BLANK;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_BLANK: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pat_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            pat_q[wr_addr_i] <= wr_data_i;
        end
    end

    decoder3to8 u_decoder (
        .idx_i    (idx_q),
        .onehot_o (dec_onehot)
    );

    assign sel_valid    = (state_q == ST_DRIVE);
    assign sel_valid_o  = sel_valid;
    assign sel_idx_o    = idx_q;
    assign seg_o        = sel_valid ? pat_q[idx_q] : 8'h00;
    assign digit_sel_o  = dec_onehot & {NUM_DIGITS{sel_valid}};
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// tb/tb_display_scan_sequencer.sv - self-checking bench with a slot/phase reference model
module tb_display_scan_sequencer;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] mask;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    logic [2:0] sel_idx    [2];
    logic       sel_valid  [2];
    logic [7:0] digit_sel  [2];
    logic [7:0] seg        [2];
    logic       frame_done [2];

    always #5 clk = ~clk;

    display_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) u_dut_b1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mask_i(mask), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .sel_idx_o(sel_idx[0]),
        .sel_valid_o(sel_valid[0]), .digit_sel_o(digit_sel[0]), .seg_o(seg[0]),
        .frame_done_o(frame_done[0])
    );

    display_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_dut_b0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mask_i(mask), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .sel_idx_o(sel_idx[1]),
        .sel_valid_o(sel_valid[1]), .digit_sel_o(digit_sel[1]), .seg_o(seg[1]),
        .frame_done_o(frame_done[1])
    );

    // Reference: each enabled digit owns a slot of `period` cycles; it is driven for the first DWELL.
    int period   [2] = '{5, 4};
    int m_active [2];
    int m_digit  [2];
    int m_phase  [2];
    int m_fd     [2];
    int m_pat    [8];
    int last_fd  [2];
    int fd_gap   [2];
    int cyc;
    int compared;
    int mismatched;

    function automatic int search_after(input int cur, input logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            if (m[(cur + k) % 8]) return (cur + k) % 8;
        end
        return cur;
    endfunction

    task automatic model_edge();
        int nd;
        for (int i = 0; i < 2; i++) begin
            m_fd[i] = 0;
            if (rst) begin
                m_active[i] = 0; m_digit[i] = 0; m_phase[i] = 0;
            end else if (!en) begin
                m_active[i] = 0; m_phase[i] = 0;
            end else if (m_active[i] == 0) begin
                if (mask != 8'h00) begin
                    m_active[i] = 1; m_digit[i] = search_after(7, mask); m_phase[i] = 0;
                end
            end else begin
                m_phase[i] = m_phase[i] + 1;
                if (m_phase[i] == period[i]) begin
                    m_phase[i] = 0;
                    if (mask == 8'h00) begin
                        m_active[i] = 0;
                    end else begin
                        nd = search_after(m_digit[i], mask);
                        m_fd[i] = (nd <= m_digit[i]) ? 1 : 0;
                        m_digit[i] = nd;
                    end
                end
            end
        end
        if (rst) begin
            for (int p = 0; p < 8; p++) m_pat[p] = 0;
        end else if (wr_en) begin
            m_pat[wr_addr] = wr_data;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle();
        int drv;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drv = (m_active[i] != 0 && m_phase[i] < DWELL) ? 1 : 0;
            check($sformatf("u%0d.sel_valid", i), 32'(sel_valid[i]), drv);
            check($sformatf("u%0d.sel_idx", i), 32'(sel_idx[i]), m_digit[i]);
            check($sformatf("u%0d.seg", i), 32'(seg[i]), (drv != 0) ? m_pat[m_digit[i]] : 0);
            check($sformatf("u%0d.digit_sel", i), 32'(digit_sel[i]), (drv != 0) ? (1 << m_digit[i]) : 0);
            check($sformatf("u%0d.frame_done", i), 32'(frame_done[i]), m_fd[i]);
            if (m_fd[i] != 0) begin
                fd_gap[i]  = cyc - last_fd[i];
                last_fd[i] = cyc;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int found;
        compared = 0; mismatched = 0; cyc = 0;
        last_fd = '{0, 0}; fd_gap = '{0, 0};
        rst = 1'b1; en = 1'b0; mask = 8'h00; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
        run(2);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'h10 + 8'(i);
            cycle();
        end
        wr_en = 1'b0;

        en = 1'b1; mask = 8'hFF;
        run(90);
        check("gap_all_b1", fd_gap[0], 40);
        check("gap_all_b0", fd_gap[1], 32);

        mask = 8'b1010_0100;
        run(50);
        check("gap_a4_b1", fd_gap[0], 15);
        check("gap_a4_b0", fd_gap[1], 12);

        mask = 8'h08;
        run(30);
        check("gap_single_b0", fd_gap[1], 4);
        check("single_valid_b0", 32'(sel_valid[1]), 1);
        check("single_idx_b0", 32'(sel_idx[1]), 3);

        mask = 8'b1010_0100;
        found = 0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            cycle();
            if (m_active[0] != 0 && m_digit[0] == 2 && m_phase[0] == 1) found = 1;
        end
        check("reach_digit2", found, 1);
        mask = 8'b1010_0000; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hAA;
        cycle();
        wr_en = 1'b0;
        check("write_shows_aa", 32'(seg[0]), 32'h0000_00AA);
        run(20);

        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            cycle();
            if (m_active[0] != 0 && m_phase[0] == 1) found = 1;
        end
        check("reach_middwell", found, 1);
        mask = 8'h00;
        run(10);
        check("mask0_valid", 32'(sel_valid[0]), 0);
        check("mask0_digit_sel", 32'(digit_sel[0]), 0);
        check("mask0_seg", 32'(seg[0]), 0);

        mask = 8'hFF;
        run(6);
        en = 1'b0;
        cycle();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h55;
        cycle();
        rst = 1'b0; wr_en = 1'b0; en = 1'b1;
        run(45);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
            if ($urandom_range(0, 40) == 0) en = ~en;
            rst = ($urandom_range(0, 120) == 0);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom);
            wr_data = 8'($urandom);
            cycle();
        end
        rst = 1'b0; wr_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
